// File: rtl/arb_pkg.sv
// Shared types, default sizes and helpers for the round-robin grant arbiter.
package arb_pkg;

    localparam int unsigned N_REQ_DEF    = 16;
    localparam int unsigned IDX_W_DEF    = 4;
    localparam int unsigned MAX_HOLD_DEF = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
        return N_REQ_DEF'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] offset;
    logic [SUM_W-1:0] sum;
    logic             found;

    // Rotate so that requester ptr sits at bit 0.
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
    end

    // Lowest set bit of the rotated vector is the distance from ptr.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[i] && !found) begin
                offset = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

    // Undo the rotation modulo N_REQ (ptr and offset are both below N_REQ).
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= SUM_W'(N_REQ)) begin
            sum = sum - SUM_W'(N_REQ);
        end
        winner  = sum[IDX_W-1:0];
        any_req = |req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter granting one shared resource; holds until done, drop, or hold limit.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam bit               HOLD_EN  = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             rel_drop;
    logic             rel_hold;
    logic             release_c;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Release terms for the current owner.
    always_comb begin
        rel_drop  = !req[idx_q];
        rel_hold  = HOLD_EN && (hold_q == HOLD_SAT);
        release_c = done || rel_drop || rel_hold;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;

        case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (any_req) begin
                    gnt_d   = N_REQ'(onehot(IDX_W_DEF'(winner)));
                    idx_d   = winner;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_c) begin
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    ptr_d     = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    timeout_d = rel_hold && !done && !rel_drop;
                    state_d   = IDLE;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_rr_grant_arbiter;

    localparam int unsigned N    = 16;
    localparam int unsigned MAXH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic [3:0]    gnt_idx;
    logic          gnt_valid;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    // Model: owner (-1 = none), next scan start, cycles the owner has held, last owner.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    rr_grant_arbiter #(
        .N_REQ    (N),
        .IDX_W    (4),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
        bit limit;
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_last  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (r[c] && m_owner < 0) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end else begin
            limit = (MAXH != 0) && (m_held >= MAXH);
            if (d || !r[m_owner] || limit) begin
                m_to    = limit && !d && r[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Apply inputs, clock once, then compare every output with the model.
    task automatic cycle(input logic [N-1:0] r, input logic d, input logic rs);
        logic [N-1:0] exp_gnt;
        req  = r;
        done = d;
        rst  = rs;
        model_step(r, d, rs);
        @(posedge clk);
        #1;
        exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("gnt",       32'(gnt),       32'(exp_gnt));
        check("gnt_idx",   32'(gnt_idx),   32'(m_last));
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("timeout",   32'(timeout),   32'(m_to));
    endtask

    logic [N-1:0] rnd_req;
    logic         rnd_done;
    logic         rnd_rst;

    initial begin
        req  = '0;
        done = 1'b0;
        rst  = 1'b1;

        // Reset held two cycles with every requester asserting.
        cycle(16'hFFFF, 1'b0, 1'b1);
        check("rst_gnt", 32'(gnt), 32'h0);
        cycle(16'hFFFF, 1'b0, 1'b1);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        cycle(16'hFFFF, 1'b0, 1'b0);
        check("first_idx", 32'(gnt_idx), 32'd0);
        check("first_gnt", 32'(gnt), 32'h0001);

        // Rotation between requesters 0 and 15 with a bubble between owners.
        cycle(16'h8001, 1'b1, 1'b0);
        check("rot_bubble", 32'(gnt_valid), 32'd0);
        cycle(16'h8001, 1'b0, 1'b0);
        check("rot_idx15", 32'(gnt_idx), 32'd15);
        cycle(16'h8001, 1'b1, 1'b0);
        cycle(16'h8001, 1'b0, 1'b0);
        check("rot_idx0", 32'(gnt_idx), 32'd0);
        cycle(16'h8001, 1'b1, 1'b0);
        cycle(16'h8001, 1'b0, 1'b0);
        check("rot_idx15b", 32'(gnt_idx), 32'd15);
        cycle(16'h8001, 1'b1, 1'b0);
        cycle(16'h0000, 1'b0, 1'b0);

        // Wrap/skip: grant 13 so the scan starts at 14, then offer 0 and 3.
        cycle(16'h2000, 1'b0, 1'b0);
        check("wrap_13", 32'(gnt_idx), 32'd13);
        cycle(16'h2000, 1'b1, 1'b0);
        cycle(16'h0009, 1'b0, 1'b0);
        check("wrap_0", 32'(gnt_idx), 32'd0);
        cycle(16'h0009, 1'b1, 1'b0);
        cycle(16'h0009, 1'b0, 1'b0);
        check("wrap_3", 32'(gnt_idx), 32'd3);
        cycle(16'h0009, 1'b1, 1'b0);

        // Hold limit: single requester 2 never signals done.
        cycle(16'h0004, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(16'h0004, 1'b0, 1'b0);
        check("to_held", 32'(gnt), 32'h0004);
        cycle(16'h0004, 1'b0, 1'b0);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_gnt0", 32'(gnt), 32'h0);
        cycle(16'h0004, 1'b0, 1'b0);
        check("to_regrant", 32'(gnt_idx), 32'd2);
        check("to_clear", 32'(timeout), 32'd0);

        // done on the final allowed cycle suppresses the timeout pulse.
        for (int i = 0; i < 3; i++) cycle(16'h0004, 1'b0, 1'b0);
        cycle(16'h0004, 1'b1, 1'b0);
        check("sim_to", 32'(timeout), 32'd0);
        check("sim_valid", 32'(gnt_valid), 32'd0);

        // Reset during a grant to requester 8.
        cycle(16'h0100, 1'b0, 1'b0);
        check("mid_gnt", 32'(gnt), 32'h0100);
        cycle(16'h0100, 1'b0, 1'b1);
        check("mid_rst", 32'(gnt), 32'h0);
        cycle(16'h0101, 1'b0, 1'b0);
        check("mid_idx", 32'(gnt_idx), 32'd0);
        cycle(16'h0101, 1'b1, 1'b0);

        // Random traffic: mostly persistent requests with occasional flips.
        rnd_req = 16'(($urandom));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = rnd_req ^ (N'(1) << $urandom_range(0, N - 1));
            if ($urandom_range(0, 15) == 0) rnd_req = 16'($urandom) & 16'($urandom);
            rnd_done = ($urandom_range(0, 4) == 0);
            rnd_rst  = ($urandom_range(0, 199) == 0);
            cycle(rnd_req, rnd_done, rnd_rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
